// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: bubble encoding, reset PC, fetch FSM encoding
// and IF/ID field widths used by fetch and decode.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC      = 32'h0000_0000;
  localparam int          IF_ID_PC_W    = 32;
  localparam int          IF_ID_INSTR_W = 32;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register carrying {pc, instr, valid}; bubble beats hold beats load.
// A bubble clears the PC and loads the NOP encoding with valid deasserted.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter int                 PC_W    = IF_ID_PC_W,
  parameter int                 INSTR_W = IF_ID_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP     = INSTR_W'(NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bubble_i,
  input  logic               hold_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               valid_o
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;

  always_comb begin
    pc_d    = pc_i;
    instr_d = instr_i;
    valid_d = 1'b1;
    if (bubble_i) begin
      pc_d    = '0;
      instr_d = NOP;
      valid_d = 1'b0;
    end else if (hold_i) begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational ROM and
// fills IF/ID; a zero ROM word marks end of program and freezes fetch.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [31:0]           RESET_PC   = pipeline_pkg::RESET_PC,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(pipeline_pkg::NOP_INSTR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  branch_taken_i,
  input  logic [31:0]           branch_target_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [31:0]           if_id_pc_o,
  output logic [DATA_WIDTH-1:0] if_id_instr_o,
  output logic                  if_id_valid_o,
  output logic                  halt_o,
  output logic [31:0]           fetch_count_o
);

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  count_q, count_d;
  fetch_state_e state_q, state_d;
  logic         bubble, hold;

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    state_d = state_q;
    bubble  = 1'b0;
    hold    = 1'b0;
    if (branch_taken_i) begin
      // Low bits are silently dropped; misaligned targets are not an error.
      pc_d    = branch_target_i & ~32'h3;
      state_d = ST_RUN;
      bubble  = 1'b1;
    end else if (flush_i) begin
      bubble = 1'b1;
      if (!stall_i) pc_d = pc_q + 32'd4;
    end else if (stall_i) begin
      hold = 1'b1;
    end else if (state_q == ST_HALT) begin
      bubble = 1'b1;
    end else if (rom_data_i != '0) begin
      pc_d    = pc_q + 32'd4;
      count_d = count_q + 32'd1;
    end else begin
      bubble  = 1'b1;
      state_d = ST_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  if_id_reg #(
    .PC_W    (32),
    .INSTR_W (DATA_WIDTH),
    .NOP     (NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .bubble_i (bubble),
    .hold_i   (hold),
    .pc_i     (pc_q),
    .instr_i  (rom_data_i),
    .pc_o     (if_id_pc_o),
    .instr_o  (if_id_instr_o),
    .valid_o  (if_id_valid_o)
  );

  // Upper PC bits are ignored, so the ROM aliases across the address space.
  assign rom_addr_o    = pc_q[ADDR_WIDTH+1:2];
  assign halt_o        = (state_q == ST_HALT);
  assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table for stall/redirect/flush
// sequences, plus hand-written end-of-program and reset-during-halt sequences.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, branch_taken_i;
  logic [31:0] branch_target_i;
  logic [7:0]  rom_addr_o;
  logic [31:0] rom_data_i;
  logic [31:0] if_id_pc_o, if_id_instr_o, fetch_count_o;
  logic        if_id_valid_o, halt_o;

  logic [31:0] rom [0:255];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign rom_data_i = rom[rom_addr_o];

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .rom_addr_o      (rom_addr_o),
    .rom_data_i      (rom_data_i),
    .if_id_pc_o      (if_id_pc_o),
    .if_id_instr_o   (if_id_instr_o),
    .if_id_valid_o   (if_id_valid_o),
    .halt_o          (halt_o),
    .fetch_count_o   (fetch_count_o)
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_halt;
    logic [31:0] e_count;
    logic [7:0]  e_addr;
  } vec_t;

  vec_t vecs [0:15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                         input logic e_valid, input logic e_halt, input logic [31:0] e_count,
                         input logic [7:0] e_addr);
    $display("%s: pc=%08h instr=%08h valid=%0b halt=%0b count=%0d addr=%0d",
             tag, if_id_pc_o, if_id_instr_o, if_id_valid_o, halt_o, fetch_count_o, rom_addr_o);
    if (e_valid) chk({tag, " if_id_pc"}, if_id_pc_o, e_pc);
    chk({tag, " if_id_instr"}, if_id_instr_o, e_instr);
    chk({tag, " if_id_valid"}, {31'd0, if_id_valid_o}, {31'd0, e_valid});
    chk({tag, " halt"}, {31'd0, halt_o}, {31'd0, e_halt});
    chk({tag, " fetch_count"}, fetch_count_o, e_count);
    chk({tag, " rom_addr"}, {24'd0, rom_addr_o}, {24'd0, e_addr});
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic b, input logic [31:0] t);
    rst = r; stall_i = s; flush_i = f; branch_taken_i = b; branch_target_i = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic s, input logic f, input logic b, input logic [31:0] t,
                              input logic [31:0] p, input logic [31:0] i, input logic v,
                              input logic h, input logic [31:0] c, input logic [7:0] a);
    vec_t x;
    x.stall = s; x.flush = f; x.br = b; x.tgt = t;
    x.e_pc = p; x.e_instr = i; x.e_valid = v; x.e_halt = h; x.e_count = c; x.e_addr = a;
    return x;
  endfunction

  initial begin
    logic [31:0] prog [0:20];
    prog = '{32'h00052503, 32'h0045a583, 32'h00b50633, 32'h00c2a423, 32'h00100093,
             32'h00200113, 32'h00308193, 32'h00410213, 32'h00518293, 32'h00620313,
             32'h00728393, 32'h00830413, 32'h00c6f6b3, 32'h00940493, 32'h00a48513,
             32'h00b50593, 32'h00c58613, 32'h00d60693, 32'h00e68713, 32'h00f70793,
             32'h01078813};
    for (int i = 0; i < 256; i++) rom[i] = (i < 21) ? prog[i] : 32'h0;

    //            stall flush br  tgt     pc      instr         v  h  cnt addr
    vecs[0]  = mk(0, 0, 0, 32'h0,  32'h00, 32'h00052503, 1, 0, 1, 1);
    vecs[1]  = mk(0, 0, 0, 32'h0,  32'h04, 32'h0045a583, 1, 0, 2, 2);
    vecs[2]  = mk(0, 0, 0, 32'h0,  32'h08, 32'h00b50633, 1, 0, 3, 3);
    vecs[3]  = mk(1, 0, 0, 32'h0,  32'h08, 32'h00b50633, 1, 0, 3, 3);
    vecs[4]  = mk(1, 0, 0, 32'h0,  32'h08, 32'h00b50633, 1, 0, 3, 3);
    vecs[5]  = mk(1, 0, 0, 32'h0,  32'h08, 32'h00b50633, 1, 0, 3, 3);
    vecs[6]  = mk(0, 0, 0, 32'h0,  32'h0C, 32'h00c2a423, 1, 0, 4, 4);
    vecs[7]  = mk(1, 0, 1, 32'h30, 32'h00, 32'h00000013, 0, 0, 4, 12);
    vecs[8]  = mk(0, 0, 0, 32'h0,  32'h30, 32'h00c6f6b3, 1, 0, 5, 13);
    vecs[9]  = mk(0, 1, 0, 32'h0,  32'h00, 32'h00000013, 0, 0, 5, 14);
    vecs[10] = mk(0, 0, 0, 32'h0,  32'h38, 32'h00a48513, 1, 0, 6, 15);
    vecs[11] = mk(0, 0, 1, 32'h33, 32'h00, 32'h00000013, 0, 0, 6, 12);
    vecs[12] = mk(0, 0, 0, 32'h0,  32'h30, 32'h00c6f6b3, 1, 0, 7, 13);
    vecs[13] = mk(1, 1, 0, 32'h0,  32'h00, 32'h00000013, 0, 0, 7, 13);
    vecs[14] = mk(0, 0, 0, 32'h0,  32'h34, 32'h00940493, 1, 0, 8, 14);
    vecs[15] = mk(0, 0, 1, 32'h0,  32'h00, 32'h00000013, 0, 0, 8, 0);

    drive(1, 0, 0, 0, 32'h0);
    step();
    chk_all("reset", 32'h0, 32'h00000013, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 32'h0);

    for (int i = 0; i < 16; i++) begin
      drive(0, vecs[i].stall, vecs[i].flush, vecs[i].br, vecs[i].tgt);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_valid,
              vecs[i].e_halt, vecs[i].e_count, vecs[i].e_addr);
    end

    // Free run from reset to end of program at word 21.
    drive(1, 0, 0, 0, 32'h0);
    step();
    drive(0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 21; i++) begin
      step();
      chk_all($sformatf("run%0d", i), 32'(i * 4), prog[i], 1, 0, 32'(i + 1), 8'(i + 1));
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("halt%0d", i), 32'h0, 32'h00000013, 0, 1, 21, 21);
    end
    drive(0, 0, 0, 1, 32'h0);
    step();
    chk_all("halt_redirect", 32'h0, 32'h00000013, 0, 0, 21, 0);
    drive(0, 0, 0, 0, 32'h0);
    step();
    chk_all("refetch", 32'h0, 32'h00052503, 1, 0, 22, 1);

    // Reach halt again, then reset together with a redirect.
    drive(0, 0, 0, 1, 32'h50);
    step();
    drive(0, 0, 0, 0, 32'h0);
    step();
    chk_all("w20", 32'h50, 32'h01078813, 1, 0, 23, 21);
    step();
    chk_all("halt_again", 32'h0, 32'h00000013, 0, 1, 23, 21);
    drive(1, 0, 0, 1, 32'h40);
    step();
    chk_all("rst_br", 32'h0, 32'h00000013, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 32'h0);
    step();
    chk_all("rst_hold", 32'h0, 32'h00000013, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 32'h0);
    step();
    chk_all("post_rst", 32'h0, 32'h00052503, 1, 0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
